// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: FSM encoding, default slave
// windows and the registered transfer record.
package apb_bridge_pkg;

    localparam int NUM_SLV = 3;

    // Slave windows are 64 MB, so only the top 6 address bits select a slave.
    localparam int WIN_W = 6;

    localparam logic [31:0] DEF_SLV0_BASE = 32'h8000_0000;
    localparam logic [31:0] DEF_SLV1_BASE = 32'h8400_0000;
    localparam logic [31:0] DEF_SLV2_BASE = 32'h8800_0000;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ENABLE = 2'd2;
    localparam logic [1:0] ST_ERR    = 2'd3;

    typedef struct packed {
        logic               write;
        logic [31:0]        addr;
        logic [31:0]        wdata;
        logic [NUM_SLV-1:0] sel;
    } xfer_t;

    function automatic logic win_hit(input logic [31:0] addr, input logic [31:0] base);
        return addr[31 -: WIN_W] == base[31 -: WIN_W];
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave decoder: maps an address onto a one-hot APB select.
module apb_addr_decode
    import apb_bridge_pkg::*;
#(
    parameter logic [31:0] SLV0_BASE = DEF_SLV0_BASE,
    parameter logic [31:0] SLV1_BASE = DEF_SLV1_BASE,
    parameter logic [31:0] SLV2_BASE = DEF_SLV2_BASE
) (
    input  logic [31:0]        addr,
    output logic [NUM_SLV-1:0] psel,
    output logic               hit
);

    // Priority chain keeps psel one-hot even if two bases share a window.
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        psel = '0;
        if (win_hit(addr, SLV0_BASE)) begin
            psel = 3'b001;
        end else if (win_hit(addr, SLV1_BASE)) begin
            psel = 3'b010;
        end else if (win_hit(addr, SLV2_BASE)) begin
            psel = 3'b100;
        end
    end

    assign hit = |psel;

endmodule

// File: rtl/apb_controller.sv
// AHB-side request to APB master bridge: one transfer in flight, optional
// ENABLE wait states, back-to-back acceptance and a one-cycle error response.
module apb_controller
    import apb_bridge_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] SLV0_BASE   = DEF_SLV0_BASE,
    parameter logic [31:0] SLV1_BASE   = DEF_SLV1_BASE,
    parameter logic [31:0] SLV2_BASE   = DEF_SLV2_BASE
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] prdata,
    output logic        req_ready,
    output logic        xfer_done,
    output logic [31:0] hrdata,
    output logic [2:0]  psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [3:0]         wait_cnt_q;
    xfer_t              xfer_q;
    logic [31:0]        hrdata_q;
    logic [NUM_SLV-1:0] dec_psel;
    logic               dec_hit;
    logic               last_enable;
    logic               accept;

    apb_addr_decode #(
        .SLV0_BASE (SLV0_BASE),
        .SLV1_BASE (SLV1_BASE),
        .SLV2_BASE (SLV2_BASE)
    ) u_decode (
        .addr (req_addr),
        .psel (dec_psel),
        .hit  (dec_hit)
    );

    assign last_enable = (state_q == ST_ENABLE) && (wait_cnt_q == '0);
    assign req_ready   = (state_q == ST_IDLE) || last_enable;
    assign accept      = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = dec_hit ? ST_SETUP : ST_ERR;
        end else begin
            case (state_q)
                ST_SETUP:  state_d = ST_ENABLE;
                ST_ENABLE: if (last_enable) state_d = ST_IDLE;
                ST_ERR:    state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            xfer_q     <= '0;
            hrdata_q   <= '0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                xfer_q <= '{write: req_write, addr: req_addr, wdata: req_wdata, sel: dec_psel};
            end

            // The wait counter is armed when SETUP is entered and drains during ENABLE.
            if (accept && dec_hit) begin
                wait_cnt_q <= WAIT_LOAD;
            end else if (state_q == ST_ENABLE && wait_cnt_q != '0) begin
                wait_cnt_q <= wait_cnt_q - 4'd1;
            end

            // An error response reports zero read data for its whole cycle.
            if (accept && !dec_hit) begin
                hrdata_q <= '0;
            end else if (last_enable && !xfer_q.write) begin
                hrdata_q <= prdata;
            end
        end
    end

    assign psel      = (state_q == ST_SETUP || state_q == ST_ENABLE) ? xfer_q.sel : '0;
    assign penable   = (state_q == ST_ENABLE);
    assign xfer_done = last_enable || (state_q == ST_ERR);
    assign paddr     = xfer_q.addr;
    assign pwrite    = xfer_q.write;
    assign pwdata    = xfer_q.wdata;
    assign hrdata    = hrdata_q;

endmodule

// File: tb/tb_apb_controller.sv
// Scoreboard bench for apb_controller: two environments (0 and 2 wait states)
// with directed scenarios followed by random traffic against a transaction model.
module tb_apb_controller;

    typedef struct {
        logic        err;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [2:0]  sel;
        int          due;
    } exp_t;

    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    int cyc = 0;
    always @(posedge hclk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input int env, input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL [wait=%0d] %s: got=%h want=%h (t=%0t)", env, name, act, exp, $time);
        end
    endtask

    // Slave select from the address map: 64 MB windows at 0x80.., 0x84.., 0x88..
    function automatic logic [2:0] model_sel(input logic [31:0] a);
        logic [31:0] bases [3];
        bases = '{32'h8000_0000, 32'h8400_0000, 32'h8800_0000};
        for (int i = 0; i < 3; i++) begin
            if ((a >> 26) == (bases[i] >> 26)) return 3'(1 << i);
        end
        return 3'b000;
    endfunction

    function automatic logic [5:0] mem_idx(input logic [31:0] a);
        return {a[27:26], a[5:2]};
    endfunction

    function automatic logic [31:0] mem_init(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'hC3A5_0000;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [5:0] top;
        case ($urandom_range(0, 3))
            0: top = 6'h20;
            1: top = 6'h21;
            2: top = 6'h22;
            default: begin
                top = 6'($urandom_range(0, 63));
                if (top inside {6'h20, 6'h21, 6'h22}) top = 6'h3F;
            end
        endcase
        return {top, 26'($urandom)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_env
        localparam int W = (g == 0) ? 0 : 2;

        logic        hresetn, req_valid, req_write, req_ready, xfer_done, penable, pwrite;
        logic [31:0] req_addr, req_wdata, prdata, hrdata, paddr, pwdata;
        logic [2:0]  psel;

        logic [31:0] slave_mem [64];
        logic [31:0] shadow [64];
        logic [31:0] junk;
        exp_t        q[$];
        logic [31:0] exp_hr;
        int          en_run;
        bit          saw_setup;
        bit          done_flag = 1'b0;

        apb_controller #(.WAIT_CYCLES(W)) dut (
            .hclk      (hclk),
            .hresetn   (hresetn),
            .req_valid (req_valid),
            .req_write (req_write),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .prdata    (prdata),
            .req_ready (req_ready),
            .xfer_done (xfer_done),
            .hrdata    (hrdata),
            .psel      (psel),
            .penable   (penable),
            .pwrite    (pwrite),
            .paddr     (paddr),
            .pwdata    (pwdata)
        );

        // APB slave: valid data only during ENABLE, garbage otherwise.
        assign prdata = penable ? slave_mem[mem_idx(paddr)] : junk;

        always @(posedge hclk) begin
            junk <= $urandom;
            if (cyc == 0) begin
                for (int i = 0; i < 64; i++) slave_mem[i] <= mem_init(i);
            end else if (hresetn && xfer_done && penable && pwrite) begin
                slave_mem[mem_idx(paddr)] <= pwdata;
            end
        end

        // Monitor: pops the expected transfer whenever the DUT reports completion.
        always @(negedge hclk) begin : mon
            exp_t e;
            bit   have;
            bit   popped;
            if (!hresetn) begin
                q.delete();
                en_run    = 0;
                saw_setup = 1'b0;
                exp_hr    = '0;
            end else begin
                popped = 1'b0;
                check(W, "psel_onehot", 32'($countones(psel) <= 1), 32'd1);
                if (psel != 3'b000 && !penable) saw_setup = 1'b1;
                if (penable) en_run++;
                have = q.size() > 0;
                if (have && cyc > q[0].due) begin
                    check(W, "latency_timeout", cyc, q[0].due);
                    e = q.pop_front();
                    have = q.size() > 0;
                end
                if (!have) check(W, "idle_quiet", {28'd0, psel, penable}, 32'd0);
                check(W, "req_ready", 32'(req_ready), 32'(!have || (xfer_done && !q[0].err)));
                if (xfer_done) begin
                    if (!have) begin
                        check(W, "spurious_done", 32'(xfer_done), 32'd0);
                    end else begin
                        e = q.pop_front();
                        popped = 1'b1;
                        check(W, "done_latency", cyc, e.due);
                        check(W, "done_psel", 32'(psel), 32'(e.err ? 3'b000 : e.sel));
                        check(W, "done_penable", 32'(penable), 32'(!e.err));
                        if (e.err) begin
                            exp_hr = '0;
                        end else begin
                            check(W, "paddr", paddr, e.addr);
                            check(W, "pwrite", 32'(pwrite), 32'(e.write));
                            if (e.write) check(W, "pwdata", pwdata, e.wdata);
                            check(W, "enable_cycles", en_run, 1 + W);
                            check(W, "setup_seen", 32'(saw_setup), 32'd1);
                        end
                        en_run    = 0;
                        saw_setup = 1'b0;
                    end
                end
                check(W, "hrdata", hrdata, exp_hr);
                if (popped && !e.err && !e.write) exp_hr = e.rdata;
            end
        end

        task automatic idle(input int n);
            repeat (n) begin
                @(negedge hclk);
                #1;
                req_valid = 1'b0;
                req_write = 1'($urandom);
                req_addr  = $urandom;
                req_wdata = $urandom;
            end
        endtask

        // Waits for req_ready (junk on req_* meanwhile), presents the request and records its expectation.
        task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
            exp_t e;
            int   guard;
            guard = 0;
            forever begin
                @(negedge hclk);
                #1;
                if (req_ready) break;
                req_valid = 1'b1;
                req_write = 1'($urandom);
                req_addr  = $urandom;
                req_wdata = $urandom;
                guard++;
                if (guard > 40) begin
                    check(W, "ready_timeout", 32'(req_ready), 32'd1);
                    req_valid = 1'b0;
                    return;
                end
            end
            req_valid = 1'b1;
            req_write = wr;
            req_addr  = a;
            req_wdata = d;
            e.sel   = model_sel(a);
            e.err   = (e.sel == 3'b000);
            e.write = wr;
            e.addr  = a;
            e.wdata = d;
            e.rdata = '0;
            if (!e.err) begin
                if (wr) shadow[mem_idx(a)] = d;
                else    e.rdata = shadow[mem_idx(a)];
            end
            e.due = cyc + (e.err ? 1 : 2 + W);
            q.push_back(e);
        endtask

        initial begin : drv
            bit seen_enable;
            for (int i = 0; i < 64; i++) shadow[i] = mem_init(i);
            hresetn   = 1'b0;
            req_valid = 1'b0;
            req_write = 1'b0;
            req_addr  = '0;
            req_wdata = '0;
            repeat (3) @(negedge hclk);
            #1;
            check(W, "rst_req_ready", 32'(req_ready), 32'd1);
            check(W, "rst_outputs", {28'd0, psel, penable}, 32'd0);
            check(W, "rst_xfer_done", 32'(xfer_done), 32'd0);
            check(W, "rst_hrdata", hrdata, 32'd0);
            check(W, "rst_paddr", paddr, 32'd0);
            check(W, "rst_pwdata", pwdata, 32'd0);
            check(W, "rst_pwrite", 32'(pwrite), 32'd0);
            hresetn = 1'b1;

            issue(1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
            idle(3);
            issue(1'b1, 32'h8400_0004, 32'h0000_00A5);
            idle(2);
            issue(1'b0, 32'h8400_0004, 32'h0);
            idle(6);
            check(W, "read_a5", hrdata, 32'h0000_00A5);

            issue(1'b1, 32'h8800_0000, $urandom);
            issue(1'b1, 32'h8000_0000, $urandom);
            idle(4);

            issue(1'b0, 32'h9000_0000, 32'h0);
            idle(3);
            check(W, "err_hrdata", hrdata, 32'd0);

            issue(1'b0, 32'h8000_0020, 32'h0);
            seen_enable = 1'b0;
            for (int i = 0; i < 8 && !seen_enable; i++) begin
                @(negedge hclk);
                #1;
                req_valid = 1'b0;
                seen_enable = penable;
            end
            check(W, "reset_reached_enable", 32'(seen_enable), 32'd1);
            #2 hresetn = 1'b0;
            #1;
            check(W, "rst_mid_psel", 32'(psel), 32'd0);
            check(W, "rst_mid_penable", 32'(penable), 32'd0);
            check(W, "rst_mid_done", 32'(xfer_done), 32'd0);
            check(W, "rst_mid_ready", 32'(req_ready), 32'd1);
            @(negedge hclk);
            #1 hresetn = 1'b1;
            issue(1'b0, 32'h8800_0014, 32'h0);
            idle(6);

            for (int n = 0; n < 80; n++) begin
                issue(1'($urandom), rand_addr(), $urandom);
                idle($urandom_range(0, 2));
            end
            idle(8);
            done_flag = 1'b1;
        end
    end

    initial begin : summary
        int guard;
        guard = 0;
        while (!(g_env[0].done_flag && g_env[1].done_flag) && guard < 20000) begin
            @(posedge hclk);
            guard++;
        end
        if (guard >= 20000) begin
            total++;
            bad++;
            $display("FAIL run_timeout: got=stalled want=finished");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
